// File: rtl/random.sv
// Fibonacci XNOR LFSR of width N; the all-zeros state is the reset point.
// The all-ones lockup state is forced back to zero.
module random #(
  parameter int N = 3
) (
  input  logic       clk,
  input  logic       rst,
  output logic [1:N] Q
);

  if (N < 2 || N > 24) begin : g_bad_width
    $fatal(1, "random: N=%0d is outside the legal range 2..24", N);
  end

  // Bit t (1-based, MSB first) is set when Q[t] feeds the XNOR.
  function automatic logic [1:24] tap_set(input int n);
    logic [1:24] m;
    m = '0;
    case (n)
      2:  begin m[2]  = 1'b1; m[1]  = 1'b1; end
      3:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
      4:  begin m[4]  = 1'b1; m[3]  = 1'b1; end
      5:  begin m[5]  = 1'b1; m[3]  = 1'b1; end
      6:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
      7:  begin m[7]  = 1'b1; m[6]  = 1'b1; end
      8:  begin m[8]  = 1'b1; m[6]  = 1'b1; m[5]  = 1'b1; m[4] = 1'b1; end
      9:  begin m[9]  = 1'b1; m[5]  = 1'b1; end
      10: begin m[10] = 1'b1; m[7]  = 1'b1; end
      11: begin m[11] = 1'b1; m[9]  = 1'b1; end
      12: begin m[12] = 1'b1; m[6]  = 1'b1; m[4]  = 1'b1; m[1] = 1'b1; end
      13: begin m[13] = 1'b1; m[4]  = 1'b1; m[3]  = 1'b1; m[1] = 1'b1; end
      14: begin m[14] = 1'b1; m[5]  = 1'b1; m[3]  = 1'b1; m[1] = 1'b1; end
      15: begin m[15] = 1'b1; m[14] = 1'b1; end
      16: begin m[16] = 1'b1; m[15] = 1'b1; m[13] = 1'b1; m[4] = 1'b1; end
      17: begin m[17] = 1'b1; m[14] = 1'b1; end
      18: begin m[18] = 1'b1; m[11] = 1'b1; end
      19: begin m[19] = 1'b1; m[6]  = 1'b1; m[2]  = 1'b1; m[1] = 1'b1; end
      20: begin m[20] = 1'b1; m[17] = 1'b1; end
      21: begin m[21] = 1'b1; m[19] = 1'b1; end
      22: begin m[22] = 1'b1; m[21] = 1'b1; end
      23: begin m[23] = 1'b1; m[18] = 1'b1; end
      24: begin m[24] = 1'b1; m[23] = 1'b1; m[22] = 1'b1; m[17] = 1'b1; end
      default: m = '0;
    endcase
    return m;
  endfunction

  localparam logic [1:24] TAP_ALL = tap_set(N);
  localparam logic [1:N]  TAPS    = TAP_ALL[1:N];

  logic       fb;
  logic       lockup;
  logic [1:N] next_q;

  // XNOR feedback keeps zero as a legal seed; all-ones is the only dead state.
  always_comb begin
    fb     = ~(^(Q & TAPS));
    lockup = &Q;
    next_q = {fb, Q[1:N-1]};
    if (lockup) next_q = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) Q <= '0;
    else     Q <= next_q;
  end

endmodule

// File: tb/tb_random.sv
// Self-checking bench for random: N=3 directed sequences plus full-period runs
// for N=8 and N=16, all checked against an integer LFSR model.
module tb_random;

  logic        clk = 1'b0;
  logic        rst3;
  logic        rst_big;
  logic [1:3]  q3;
  logic [1:8]  q8;
  logic [1:16] q16;

  int total = 0;
  int bad   = 0;

  int m3 = 0, m8 = 0, m16 = 0;
  bit v3 = 1'b0, vbig = 1'b0;
  bit inject = 1'b0;

  always #5 clk = ~clk;

  random #(.N(3))  dut3  (.clk(clk), .rst(rst3),    .Q(q3));
  random #(.N(8))  dut8  (.clk(clk), .rst(rst_big), .Q(q8));
  random #(.N(16)) dut16 (.clk(clk), .rst(rst_big), .Q(q16));

  // State as an integer, MSB = bit 1; feedback = 1 ^ parity of tapped bits.
  function automatic int step(input int s, input int n);
    int taps[$];
    int x;
    int all_ones;
    all_ones = (1 << n) - 1;
    case (n)
      3:       taps = '{3, 2};
      8:       taps = '{8, 6, 5, 4};
      16:      taps = '{16, 15, 13, 4};
      default: taps = '{n, n - 1};
    endcase
    if (s == all_ones) return 0;
    x = 0;
    foreach (taps[k]) x = x ^ ((s >> (n - taps[k])) & 1);
    return (s >> 1) | ((x ^ 1) << (n - 1));
  endfunction

  task automatic checkOutput(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit r, input int cycles);
    rst3 = r;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    m3  <= rst3    ? 0 : step(inject ? 7 : m3, 3);
    m8  <= rst_big ? 0 : step(m8, 8);
    m16 <= rst_big ? 0 : step(m16, 16);
    if (rst3)    v3   <= 1'b1;
    if (rst_big) vbig <= 1'b1;
  end

  always @(negedge clk) begin
    if (v3) checkOutput("model3", int'(q3), inject ? 7 : m3);
    if (vbig) begin
      checkOutput("model8",  int'(q8),  m8);
      checkOutput("model16", int'(q16), m16);
    end
  end

  initial begin
    int seq[8];
    int hist[8];
    int first8, first16;
    bit seen8, seen16;
    seq = '{4, 6, 3, 5, 2, 1, 0, 4};
    hist = '{default: 0};
    first8 = 0; first16 = 0; seen8 = 1'b0; seen16 = 1'b0;

    rst_big = 1'b1;
    applyStimulus(1'b1, 1);
    checkOutput("reset3",  int'(q3),  0);
    checkOutput("reset8",  int'(q8),  0);
    checkOutput("reset16", int'(q16), 0);
    rst_big = 1'b0;
    rst3    = 1'b0;

    fork
      begin
        foreach (seq[i]) begin
          applyStimulus(1'b0, 1);
          checkOutput("seq3", int'(q3), seq[i]);
        end
        applyStimulus(1'b0, 1);
        checkOutput("seq3", int'(q3), 6);
        applyStimulus(1'b0, 1);
        checkOutput("pre_midreset", int'(q3), 3);

        for (int i = 0; i < 3; i++) begin
          applyStimulus(1'b1, 1);
          checkOutput("midreset_hold", int'(q3), 0);
        end
        applyStimulus(1'b0, 1);
        checkOutput("post_midreset", int'(q3), 4);

        applyStimulus(1'b1, 1);
        rst3 = 1'b0;
        hist[int'(q3)]++;
        for (int i = 0; i < 13; i++) begin
          applyStimulus(1'b0, 1);
          hist[int'(q3)]++;
        end
        checkOutput("hist_7", hist[7], 0);
        for (int v = 0; v < 7; v++) checkOutput("hist_value", hist[v], 2);

        #2;
        force dut3.Q = 3'b111;
        inject = 1'b1;
        #1;
        release dut3.Q;
        @(posedge clk);
        #1;
        inject = 1'b0;
        checkOutput("lockup_recover", int'(q3), 0);
        applyStimulus(1'b0, 1);
        checkOutput("lockup_next", int'(q3), 4);
      end
      begin
        checkOutput("pin_model8",  step(0, 8), 128);
        checkOutput("pin_model16", step(128, 16), 32832);
        for (int c = 1; c <= 65535; c++) begin
          @(posedge clk);
          #1;
          if (c == 1) begin
            checkOutput("first8",  int'(q8),  128);
            checkOutput("first16", int'(q16), 32768);
          end
          if (c == 2) checkOutput("second8", int'(q8), 192);
          if (q8 == 8'hFF) seen8 = 1'b1;
          if (q16 == 16'hFFFF) seen16 = 1'b1;
          if (q8 == 8'h00 && first8 == 0) first8 = c;
          if (q16 == 16'h0000 && first16 == 0) first16 = c;
        end
        checkOutput("period8",    first8,  255);
        checkOutput("period16",   first16, 65535);
        checkOutput("allones8",   int'(seen8),  0);
        checkOutput("allones16",  int'(seen16), 0);
      end
    join

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/random.md
RANDOM -- requirements
Module: random

Interface
REQ-001 SHALL have parameter N, default 3, meaning register width and LFSR length in bits; legal range 2..24.
REQ-002 SHALL have port clk, input, 1 bit; the single clock, and all state SHALL update on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit; reset is synchronous and active-high.
REQ-004 SHALL have port Q, output, N bits, declared [1:N]; current pseudo-random value, with Q[1] as MSB and Q[N] as LSB.

Function
REQ-005 SHALL implement a Fibonacci LFSR whose state register drives Q directly; no combinational path from inputs to Q.
REQ-006 SHALL, on each rising clk edge with rst low, shift: Q[1] <= fb, Q[i] <= Q[i-1] for i = 2..N.
REQ-007 SHALL compute fb as the XNOR of the tapped bits Q[t] for N's tap set (all taps XNOR-reduced).
REQ-008 SHALL select taps by N from this maximal-length table (elaboration-time case):
- 2:2,1; 3:3,2; 4:4,3; 5:5,3; 6:6,5; 7:7,6; 8:8,6,5,4; 9:9,5
- 10:10,7; 11:11,9; 12:12,6,4,1; 13:13,4,3,1; 14:14,5,3,1; 15:15,14; 16:16,15,13,4
- 17:17,14; 18:18,11; 19:19,6,2,1; 20:20,17; 21:21,19; 22:22,21; 23:23,18; 24:24,23,22,17
REQ-009 SHALL produce a sequence of period 2^N - 1 starting from all-zeros, visiting every state except all-ones.
REQ-010 SHALL detect the lockup state (all-ones, unreachable in normal operation) and, on the next rising edge with rst low, load all-zeros instead of shifting.
REQ-011 SHALL raise an elaboration-time error ($error/$fatal) when N is outside 2..24.
REQ-012 SHALL advance exactly one state per clock; there is no enable and no stall.

Reset
REQ-013 SHALL load Q = 0 (all bits zero) on any rising clk edge where rst is high, with priority over shifting and lockup recovery.
REQ-014 SHALL treat reset asserted mid-sequence identically: Q = 0 at the first rising edge sampling rst high, and Q holds 0 for as long as rst stays high.
REQ-015 SHALL resume the sequence at the first rising edge with rst low, so the first post-reset value for N=3 is 4.
REQ-016 SHALL NOT define a value for Q before the first reset; the bench SHALL apply reset before checking.

Verification
REQ-017 N=3: rst high for one edge, then low -> Q per edge 0,4,6,3,5,2,1,0,4,... (decimal, Q[1] MSB), period 7.
REQ-018 N=3: run 14 cycles after reset -> value 7 never appears and each of 0..6 appears exactly twice.
REQ-019 N=3: assert rst for one edge when Q=3 -> Q=0 at that edge, then 4 at the next edge.
REQ-020 N=3: force the state to 7 (lockup) and release with rst low -> Q=0 at the next edge, then 4.
REQ-021 N=8 and N=16: run 2^N - 1 cycles after reset -> Q returns to 0 exactly at cycle 2^N - 1, never earlier, and 2^N - 1 is never produced.
REQ-022 N=1 and N=25: elaboration -> fails with an error.
